wb_reg_timeout: RTL and testbench
=================================

# wb_reg_timeout

Registered Wishbone classic-cycle slice with a bus watchdog, inserted between an interconnect master port and a slave that may hang. It fully registers the request and response paths. It also terminates any slave cycle that exceeds a programmable cycle budget by dropping the slave cycle and returning ERR to the master. Master-side cycle aborts are propagated to the slave, and timeout events are reported and counted for firmware.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32, 64)
- ADDR_WIDTH, 32, address width in bits
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width
- TIMEOUT, 1024, slave response budget in cycles; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wbm_adr_i / wbm_dat_i / wbm_we_i / wbm_sel_i / wbm_stb_i / wbm_cyc_i  in  ADDR_WIDTH / DATA_WIDTH / 1 / SELECT_WIDTH / 1 / 1  master request
- wbm_dat_o / wbm_ack_o / wbm_err_o / wbm_rty_o  out  DATA_WIDTH / 1 / 1 / 1  registered master response
- wbs_adr_o / wbs_dat_o / wbs_we_o / wbs_sel_o / wbs_stb_o / wbs_cyc_o  out  ADDR_WIDTH / DATA_WIDTH / 1 / SELECT_WIDTH / 1 / 1  registered slave request
- wbs_dat_i / wbs_ack_i / wbs_err_i / wbs_rty_i  in  DATA_WIDTH / 1 / 1 / 1  slave response
- timeout_o  out  1  one-cycle pulse on each watchdog termination
- timeout_cnt_o  out  16  saturating count of terminations
- timeout_clr_i  in  1  synchronous clear of timeout_cnt_o
- busy_o  out  1  high in WAIT and RESP

## Operation
- Reset: every output is 0 after the first rst edge; the state is IDLE and the timer is 0. Reset mid-cycle abandons the transaction, with no response to the master.
- IDLE:
  - wbs_cyc_o and wbs_stb_o are 0.
  - On wbm_cyc_i & wbm_stb_i, capture adr, dat, we and sel into the wbs_* registers, set wbs_cyc_o and wbs_stb_o to 1, clear the timer, and go to WAIT.
- WAIT, slave response (ack|err|rty):
  - Latch wbs_dat_i into wbm_dat_o.
  - Assert exactly one master flag, with priority err > rty > ack.
  - Drop wbs_cyc_o, wbs_stb_o and wbs_we_o, then go to RESP.
- WAIT, no response, TIMEOUT≠0 and timer==TIMEOUT-1:
  - Drop the wbs cycle and set wbm_err_o=1 with wbm_dat_o=0.
  - Pulse timeout_o and increment the counter.
  - Go to RESP.
- WAIT, no response otherwise: timer+1; the timer is $clog2(TIMEOUT+1) bits and never wraps.
- WAIT, wbm_cyc_i==0 (master abort):
  - Drop the wbs cycle and go to IDLE.
  - No master response is generated, and any same-cycle slave response is discarded.
- RESP:
  - The master flag is high for exactly this one cycle, and the request input is ignored.
  - Next state is IDLE; the flags return to 0 and wbm_dat_o holds its value.
- Simultaneous events, in priority order:
  - Abort beats response, which beats timeout.
  - A response on the TIMEOUT-th WAIT edge is accepted normally.
- Counter: saturates at 0xFFFF. timeout_clr_i alone gives 0; clear together with a timeout gives 1.

## Timing
- Request latency: master stb sampled at edge n → wbs_stb_o high after edge n.
- Response latency: slave ack sampled at edge m → wbm_ack_o high after edge m, for one cycle.
- Minimum transaction: 3 cycles (IDLE→WAIT→RESP).
- With a zero-wait slave, wbm_ack_o rises 2 edges after the master first presents stb.
- Timeout: wbm_err_o rises after WAIT edge number TIMEOUT (counting the first WAIT edge as 1).
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Write adr=0x10, dat=0xDEADBEEF, sel=0xF; slave acks on its first stb cycle → wbs_* fields are captured exactly, wbm_ack_o is high for 1 cycle, busy_o is low 3 cycles after the request.
- Read adr=0x20; slave returns 0x12345678 with ack after 5 wait cycles → wbm_dat_o=0x12345678, one ack pulse, wbs_stb_o deasserted the same edge.
- TIMEOUT=8, silent slave → wbs_cyc_o drops and wbm_err_o=1 after WAIT edge 8, timeout_o pulses once, timeout_cnt_o=1, wbm_dat_o=0.
- TIMEOUT=8; slave acks on WAIT edge 8 → ack (not err), timeout_o stays 0; slave asserts err+ack together → only wbm_err_o.
- Master drops cyc in WAIT cycle 3 while the slave acks that same cycle → no master response, wbs_cyc_o low next edge, state IDLE.
- Counter preset to 0xFFFF by forcing timeouts, then one more timeout → stays 0xFFFF; clear coinciding with a timeout → 1; rst mid-WAIT → all outputs 0.

Source files
------------

// File: rtl/wb_reg_timeout.sv
// Registered Wishbone classic-cycle slice with a slave-response watchdog.
// Request and response paths are fully registered; a slave cycle that runs
// past TIMEOUT cycles is dropped and answered with ERR to the master.
module wb_reg_timeout #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
   input  logic                    wbm_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
   input  logic                    wbm_stb_i,
   input  logic                    wbm_cyc_i,
   output logic [DATA_WIDTH-1:0]   wbm_dat_o,
   output logic                    wbm_ack_o,
   output logic                    wbm_err_o,
   output logic                    wbm_rty_o,
   output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
   output logic [DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                    wbs_we_o,
   output logic [SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                    wbs_stb_o,
   output logic                    wbs_cyc_o,
   input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic                    timeout_o,
   output logic [15:0]             timeout_cnt_o,
   input  logic                    timeout_clr_i,
   output logic                    busy_o
);

   // A disabled watchdog still needs a legal (1-bit) timer vector.
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = (TIMEOUT < 1) ? '0 : TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [ADDR_WIDTH-1:0]   wbs_adr_q, wbs_adr_d;
   logic [DATA_WIDTH-1:0]   wbs_dat_q, wbs_dat_d;
   logic                    wbs_we_q, wbs_we_d;
   logic [SELECT_WIDTH-1:0] wbs_sel_q, wbs_sel_d;
   logic                    wbs_stb_q, wbs_stb_d;
   logic                    wbs_cyc_q, wbs_cyc_d;
   logic [DATA_WIDTH-1:0]   wbm_dat_q, wbm_dat_d;
   logic                    wbm_ack_q, wbm_ack_d;
   logic                    wbm_err_q, wbm_err_d;
   logic                    wbm_rty_q, wbm_rty_d;
   logic                    timeout_q, timeout_d;
   logic [15:0]             tocnt_q, tocnt_d;
   logic                    busy_q, busy_d;

   logic                    slv_resp;

   assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

   // Next-state and next-output computation for the request/response FSM.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      wbs_adr_d = wbs_adr_q;
      wbs_dat_d = wbs_dat_q;
      wbs_we_d  = wbs_we_q;
      wbs_sel_d = wbs_sel_q;
      wbs_stb_d = wbs_stb_q;
      wbs_cyc_d = wbs_cyc_q;
      wbm_dat_d = wbm_dat_q;
      wbm_ack_d = 1'b0;
      wbm_err_d = 1'b0;
      wbm_rty_d = 1'b0;
      timeout_d = 1'b0;
      tocnt_d   = tocnt_q;

      case (state_q)
         ST_IDLE: begin
            wbs_cyc_d = 1'b0;
            wbs_stb_d = 1'b0;
            if (wbm_cyc_i && wbm_stb_i) begin
               wbs_adr_d = wbm_adr_i;
               wbs_dat_d = wbm_dat_i;
               wbs_we_d  = wbm_we_i;
               wbs_sel_d = wbm_sel_i;
               wbs_cyc_d = 1'b1;
               wbs_stb_d = 1'b1;
               timer_d   = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Priority: master abort, then slave response, then watchdog.
            if (!wbm_cyc_i) begin
               wbs_cyc_d = 1'b0;
               wbs_stb_d = 1'b0;
               wbs_we_d  = 1'b0;
               state_d   = ST_IDLE;
            end else if (slv_resp) begin
               wbm_dat_d = wbs_dat_i;
               wbm_err_d = wbs_err_i;
               wbm_rty_d = !wbs_err_i && wbs_rty_i;
               wbm_ack_d = !wbs_err_i && !wbs_rty_i;
               wbs_cyc_d = 1'b0;
               wbs_stb_d = 1'b0;
               wbs_we_d  = 1'b0;
               state_d   = ST_RESP;
            end else if (TIMEOUT != 0 && timer_q == TLAST) begin
               wbm_dat_d = '0;
               wbm_err_d = 1'b1;
               timeout_d = 1'b1;
               wbs_cyc_d = 1'b0;
               wbs_stb_d = 1'b0;
               wbs_we_d  = 1'b0;
               state_d   = ST_RESP;
            end else if (timer_q != '1) begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A clear in the same cycle as a termination still records that one.
      if (timeout_clr_i) begin
         tocnt_d = timeout_d ? 16'd1 : 16'd0;
      end else if (timeout_d && tocnt_q != 16'hFFFF) begin
         tocnt_d = tocnt_q + 16'd1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         wbs_adr_q <= '0;
         wbs_dat_q <= '0;
         wbs_we_q  <= 1'b0;
         wbs_sel_q <= '0;
         wbs_stb_q <= 1'b0;
         wbs_cyc_q <= 1'b0;
         wbm_dat_q <= '0;
         wbm_ack_q <= 1'b0;
         wbm_err_q <= 1'b0;
         wbm_rty_q <= 1'b0;
         timeout_q <= 1'b0;
         tocnt_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         wbs_adr_q <= wbs_adr_d;
         wbs_dat_q <= wbs_dat_d;
         wbs_we_q  <= wbs_we_d;
         wbs_sel_q <= wbs_sel_d;
         wbs_stb_q <= wbs_stb_d;
         wbs_cyc_q <= wbs_cyc_d;
         wbm_dat_q <= wbm_dat_d;
         wbm_ack_q <= wbm_ack_d;
         wbm_err_q <= wbm_err_d;
         wbm_rty_q <= wbm_rty_d;
         timeout_q <= timeout_d;
         tocnt_q   <= tocnt_d;
         busy_q    <= busy_d;
      end
   end

   assign wbm_dat_o     = wbm_dat_q;
   assign wbm_ack_o     = wbm_ack_q;
   assign wbm_err_o     = wbm_err_q;
   assign wbm_rty_o     = wbm_rty_q;
   assign wbs_adr_o     = wbs_adr_q;
   assign wbs_dat_o     = wbs_dat_q;
   assign wbs_we_o      = wbs_we_q;
   assign wbs_sel_o     = wbs_sel_q;
   assign wbs_stb_o     = wbs_stb_q;
   assign wbs_cyc_o     = wbs_cyc_q;
   assign timeout_o     = timeout_q;
   assign timeout_cnt_o = tocnt_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Bench for wb_reg_timeout (TIMEOUT=8): directed vector table, a few
// hand-written sequences and randomized transactions against an
// event-priority reference model.
module tb_wb_reg_timeout;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] wbm_adr_i;
   logic [DW-1:0] wbm_dat_i;
   logic          wbm_we_i;
   logic [SW-1:0] wbm_sel_i;
   logic          wbm_stb_i, wbm_cyc_i;
   logic [DW-1:0] wbm_dat_o;
   logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [AW-1:0] wbs_adr_o;
   logic [DW-1:0] wbs_dat_o;
   logic          wbs_we_o;
   logic [SW-1:0] wbs_sel_o;
   logic          wbs_stb_o, wbs_cyc_o;
   logic [DW-1:0] wbs_dat_i;
   logic          wbs_ack_i, wbs_err_i, wbs_rty_i;
   logic          timeout_o;
   logic [15:0]   timeout_cnt_o;
   logic          timeout_clr_i;
   logic          busy_o;

   always #5 clk = ~clk;

   wb_reg_timeout #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .SELECT_WIDTH(SW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_we_i(wbm_we_i),
      .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
      .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
      .wbs_rty_i(wbs_rty_i),
      .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o),
      .timeout_clr_i(timeout_clr_i), .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;

   // One transaction: stimulus plus expected outcome.
   // r: WAIT edge carrying the slave response (0 = never); kind = {err,rty,ack}.
   // a: WAIT edge at which the master drops cyc (0 = never).
   // clr_e: WAIT edge at which timeout_clr_i is pulsed (0 = never).
   // x_e: WAIT edge at which the transaction resolves.
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
      int          r;
      logic [2:0]  kind;
      logic [31:0] rdata;
      int          a;
      int          clr_e;
      logic        x_ack;
      logic        x_err;
      logic        x_rty;
      logic [31:0] x_dat;
      logic        x_to;
      int          x_e;
      logic        x_abort;
   } vec_t;

   logic [15:0] model_cnt = 16'd0;
   logic [31:0] last_dat  = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the earliest event wins; ties go abort > response > timeout.
   function automatic vec_t model(input vec_t v);
      vec_t o;
      int re, ae;
      o  = v;
      re = (v.r == 0) ? 1000 : v.r;
      ae = (v.a == 0) ? 1000 : v.a;
      o.x_ack = 1'b0; o.x_err = 1'b0; o.x_rty = 1'b0;
      o.x_to = 1'b0; o.x_abort = 1'b0; o.x_dat = 32'd0;
      if (ae <= re && ae <= TO) begin
         o.x_abort = 1'b1;
         o.x_e     = ae;
      end else if (re <= TO) begin
         o.x_e   = re;
         o.x_dat = v.rdata;
         if (v.kind[2])      o.x_err = 1'b1;
         else if (v.kind[1]) o.x_rty = 1'b1;
         else                o.x_ack = 1'b1;
      end else begin
         o.x_e   = TO;
         o.x_err = 1'b1;
         o.x_to  = 1'b1;
      end
      return o;
   endfunction

   task automatic idle_inputs();
      wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_sel_i = '0;
      wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
      wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
      timeout_clr_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".wbm_dat"}, wbm_dat_o, 0);
      chk({tag, ".flags"}, {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
      chk({tag, ".wbs_adr"}, wbs_adr_o, 0);
      chk({tag, ".wbs_dat"}, wbs_dat_o, 0);
      chk({tag, ".wbs_ctl"}, {wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o}, 0);
      chk({tag, ".timeout"}, timeout_o, 0);
      chk({tag, ".cnt"}, timeout_cnt_o, 0);
      chk({tag, ".busy"}, busy_o, 0);
   endtask

   task automatic run_txn(input vec_t v);
      logic clr_hit;
      @(negedge clk);
      wbm_adr_i = v.adr; wbm_dat_i = v.dat; wbm_we_i = v.we; wbm_sel_i = v.sel;
      wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
      @(negedge clk);
      chk("req.adr", wbs_adr_o, v.adr);
      chk("req.dat", wbs_dat_o, v.dat);
      chk("req.we", wbs_we_o, v.we);
      chk("req.sel", wbs_sel_o, v.sel);
      chk("req.cyc_stb", {wbs_cyc_o, wbs_stb_o}, 2'b11);
      chk("req.busy", busy_o, 1);
      for (int k = 1; k <= v.x_e; k++) begin
         wbm_cyc_i = (k != v.a);
         wbm_stb_i = (k != v.a);
         if (k == v.r) begin
            {wbs_err_i, wbs_rty_i, wbs_ack_i} = v.kind;
            wbs_dat_i = v.rdata;
         end else begin
            {wbs_err_i, wbs_rty_i, wbs_ack_i} = 3'b000;
            wbs_dat_i = $urandom;
         end
         timeout_clr_i = (k == v.clr_e);
         @(negedge clk);
         {wbs_err_i, wbs_rty_i, wbs_ack_i} = 3'b000;
         timeout_clr_i = 1'b0;
         if (k < v.x_e) begin
            chk("wait.cyc", wbs_cyc_o, 1);
            chk("wait.flags", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 0);
         end
      end
      clr_hit = (v.clr_e != 0 && v.clr_e <= v.x_e);
      if (clr_hit)                              model_cnt = v.x_to ? 16'd1 : 16'd0;
      else if (v.x_to && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      if (v.x_abort) begin
         chk("abort.flags", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
         chk("abort.cyc_stb", {wbs_cyc_o, wbs_stb_o}, 0);
         chk("abort.busy", busy_o, 0);
         chk("abort.dat_hold", wbm_dat_o, last_dat);
         chk("abort.timeout", timeout_o, 0);
         chk("abort.cnt", timeout_cnt_o, model_cnt);
         wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
      end else begin
         chk("resp.ack", wbm_ack_o, v.x_ack);
         chk("resp.err", wbm_err_o, v.x_err);
         chk("resp.rty", wbm_rty_o, v.x_rty);
         chk("resp.dat", wbm_dat_o, v.x_dat);
         chk("resp.wbs_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 0);
         chk("resp.timeout", timeout_o, v.x_to);
         chk("resp.cnt", timeout_cnt_o, model_cnt);
         chk("resp.busy", busy_o, 1);
         last_dat = v.x_dat;
         wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
         @(negedge clk);
         chk("post.flags", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 0);
         chk("post.busy", busy_o, 0);
         chk("post.dat_hold", wbm_dat_o, last_dat);
         chk("post.cnt", timeout_cnt_o, model_cnt);
      end
   endtask

   vec_t tbl[12];
   vec_t v;

   initial begin
      // adr, dat, we, sel, r, kind, rdata, a, clr_e, ack, err, rty, x_dat, to, e, abort
      tbl[0]  = '{32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1, 3'b001, 32'h0,        0, 0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1, 1'b0};
      tbl[1]  = '{32'h20, 32'h0,        1'b0, 4'hF, 6, 3'b001, 32'h12345678, 0, 0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 6, 1'b0};
      tbl[2]  = '{32'h30, 32'h11111111, 1'b1, 4'h3, 0, 3'b001, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 8, 1'b0};
      tbl[3]  = '{32'h40, 32'h0,        1'b0, 4'hF, 8, 3'b001, 32'hA5A5A5A5, 0, 0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 8, 1'b0};
      tbl[4]  = '{32'h44, 32'h0,        1'b0, 4'hF, 2, 3'b101, 32'h55AA55AA, 0, 0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 2, 1'b0};
      tbl[5]  = '{32'h48, 32'hCAFE,     1'b1, 4'hF, 3, 3'b001, 32'h99999999, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 3, 1'b1};
      tbl[6]  = '{32'h4C, 32'h0,        1'b0, 4'h1, 4, 3'b010, 32'h77,       0, 0, 1'b0, 1'b0, 1'b1, 32'h77,       1'b0, 4, 1'b0};
      tbl[7]  = '{32'h50, 32'h0,        1'b0, 4'hF, 1, 3'b011, 32'h88,       0, 0, 1'b0, 1'b0, 1'b1, 32'h88,       1'b0, 1, 1'b0};
      tbl[8]  = '{32'h54, 32'h0,        1'b0, 4'hF, 9, 3'b001, 32'h99,       0, 0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 8, 1'b0};
      tbl[9]  = '{32'h58, 32'h5,        1'b1, 4'h2, 0, 3'b001, 32'h0,        1, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1, 1'b1};
      tbl[10] = '{32'h5C, 32'h0,        1'b0, 4'hF, 0, 3'b001, 32'h0,        8, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8, 1'b1};
      tbl[11] = '{32'h60, 32'h0,        1'b0, 4'hF, 7, 3'b100, 32'h1234,     0, 5, 1'b0, 1'b1, 1'b0, 32'h1234,     1'b0, 7, 1'b0};

      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      foreach (tbl[i]) run_txn(tbl[i]);

      // Counter saturation: preload near the top, then terminate twice.
      @(negedge clk);
      force dut.tocnt_q = 16'hFFFE;
      #1;
      release dut.tocnt_q;
      model_cnt = 16'hFFFE;
      v = '{32'h70, 32'h0, 1'b0, 4'hF, 0, 3'b001, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0};
      run_txn(model(v));
      chk("sat.first", timeout_cnt_o, 16'hFFFF);
      run_txn(model(v));
      chk("sat.hold", timeout_cnt_o, 16'hFFFF);
      // Clear coinciding with a termination leaves a count of one.
      v.clr_e = TO;
      run_txn(model(v));
      chk("clr.with_timeout", timeout_cnt_o, 16'd1);
      // Clear alone returns the counter to zero.
      @(negedge clk);
      timeout_clr_i = 1'b1;
      @(negedge clk);
      timeout_clr_i = 1'b0;
      model_cnt = 16'd0;
      chk("clr.alone", timeout_cnt_o, 16'd0);

      for (int n = 0; n < 60; n++) begin
         v.adr   = $urandom;
         v.dat   = $urandom;
         v.we    = 1'($urandom_range(0, 1));
         v.sel   = 4'($urandom_range(0, 15));
         v.r     = $urandom_range(0, 10);
         v.kind  = 3'($urandom_range(1, 7));
         v.rdata = $urandom;
         v.a     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
         v.clr_e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, TO)) : 0;
         run_txn(model(v));
      end

      // Reset in the middle of a WAIT abandons the transaction.
      @(negedge clk);
      wbm_adr_i = 32'hABC; wbm_dat_i = 32'h5555; wbm_we_i = 1'b1; wbm_sel_i = 4'hF;
      wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midwait.busy", busy_o, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midwait_rst");
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("after_rst.busy", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
